writeback_arbiter: RTL

Writeback stage placed directly upstream of `register_32`, the register file's single write port. It accepts results from the ALU and the load unit over valid/ready handshakes and queues them in an in-order FIFO. It drains one result per cycle into `write`/`dest_add`/`data_write`, and steers R15 results onto the PC path (`write_pc`/`pc_next`). It also exports a pending-destination mask that decode uses for RAW hazard stalls.

---
 rtl/wb_pkg.sv | 12 +
 rtl/writeback_arbiter_if.sv | 40 ++++
 rtl/wb_fifo.sv | 71 +++++++
 rtl/writeback_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter
package wb_pkg;

    localparam logic [3:0] REG_PC   = 4'd15;
    localparam int         NUM_REGS = 16;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result/PC handshake bundle between producers and the writeback arbiter
interface writeback_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ld_valid;
    logic [3:0]    ld_dest;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic          alu_valid;
    logic [3:0]    alu_dest;
    logic [31:0]   alu_data;
    logic          alu_ready;
    logic          pc_inc_valid;
    logic [31:0]   pc_inc_value;
    logic          write;
    logic [3:0]    dest_add;
    logic [31:0]   data_write;
    logic          write_pc;
    logic [31:0]   pc_next;
    logic          branch_taken;
    logic [15:0]   pending_mask;
    logic [CW-1:0] fifo_count;

    modport master (
        output ld_valid, ld_dest, ld_data, alu_valid, alu_dest, alu_data,
               pc_inc_valid, pc_inc_value,
        input  ld_ready, alu_ready, write, dest_add, data_write, write_pc,
               pc_next, branch_taken, pending_mask, fifo_count
    );

    modport slave (
        input  ld_valid, ld_dest, ld_data, alu_valid, alu_dest, alu_data,
               pc_inc_valid, pc_inc_value,
        output ld_ready, alu_ready, write, dest_add, data_write, write_pc,
               pc_next, branch_taken, pending_mask, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular result FIFO with dual push, single pop, flush and dest scan
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic [1:0]          push_cnt,
    input  wb_entry_t           push_entry0,
    input  wb_entry_t           push_entry1,
    input  logic                pop,
    output wb_entry_t           head,
    output logic [CW-1:0]       count,
    output logic [NUM_REGS-1:0] pending_mask
);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_next;

    assign wr_next = wr_ptr + AW'(1);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= push_entry0;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_next] <= push_entry1;
        end
    end

    // Flush only coincides with a PC pop, when the accept logic blocks pushes.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (push_cnt != 2'd0) begin
                valid[wr_ptr] <= 1'b1;
            end
            if (push_cnt == 2'd2) begin
                valid[wr_next] <= 1'b1;
            end
            wr_ptr <= wr_ptr + AW'(push_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop);
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pending_mask[mem[i].dest] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - accepts ALU/load results, drains one per cycle to the register file, steers R15 to the PC
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic                clock,
    input logic                reset_n,
    writeback_arbiter_if.slave wb
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t           head;
    wb_entry_t           ld_entry;
    wb_entry_t           alu_entry;
    wb_entry_t           entry0;
    logic [CW-1:0]       count;
    logic [CW-1:0]       free;
    logic [NUM_REGS-1:0] pending_mask;
    logic                pop;
    logic                head_pc;
    logic                ld_ready;
    logic                alu_ready;
    logic                ld_take;
    logic                alu_take;
    logic [1:0]          push_cnt;

    assign ld_entry  = '{dest: wb.ld_dest, data: wb.ld_data};
    assign alu_entry = '{dest: wb.alu_dest, data: wb.alu_data};

    assign pop     = (count != '0);
    assign head_pc = pop && (head.dest == REG_PC);
    assign free    = CW'(FIFO_DEPTH) - count;

    // Readys use the pre-pop free count; an R15 head stalls accepts while it flushes.
    assign ld_ready  = reset_n && !head_pc && (free != '0);
    assign alu_ready = reset_n && !head_pc &&
                       ((free >= CW'(2)) || ((free != '0) && !wb.ld_valid));

    assign ld_take  = wb.ld_valid && ld_ready;
    assign alu_take = wb.alu_valid && alu_ready;
    assign push_cnt = {1'b0, ld_take} + {1'b0, alu_take};
    assign entry0   = ld_take ? ld_entry : alu_entry;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (head_pc),
        .push_cnt     (push_cnt),
        .push_entry0  (entry0),
        .push_entry1  (alu_entry),
        .pop          (pop),
        .head         (head),
        .count        (count),
        .pending_mask (pending_mask)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wb.write        <= 1'b0;
            wb.dest_add     <= '0;
            wb.data_write   <= '0;
            wb.write_pc     <= 1'b0;
            wb.pc_next      <= '0;
            wb.branch_taken <= 1'b0;
        end else if (head_pc) begin
            wb.write        <= 1'b0;
            wb.write_pc     <= 1'b1;
            wb.pc_next      <= head.data;
            wb.branch_taken <= 1'b1;
        end else begin
            wb.write        <= pop;
            wb.write_pc     <= wb.pc_inc_valid;
            wb.pc_next      <= wb.pc_inc_value;
            wb.branch_taken <= 1'b0;
            if (pop) begin
                wb.dest_add   <= head.dest;
                wb.data_write <= head.data;
            end
        end
    end

    assign wb.ld_ready     = ld_ready;
    assign wb.alu_ready    = alu_ready;
    assign wb.pending_mask = pending_mask;
    assign wb.fifo_count   = count;

endmodule
